// File: rtl/flb_search_if.sv
// Handshake bundle between the FLB search controller and its measurement and
// DCO decoder environment. The slave modport is the controller side; the master
// modport is the side that issues start and returns compare results.
interface flb_search_if;
  logic       start;
  logic       cmp_valid;
  logic       fast;
  logic       cmp_req;
  logic [7:0] s_band;
  logic [7:0] s_mtrx;
  logic       busy;
  logic       lock;

  modport master (
    output start, cmp_valid, fast,
    input  cmp_req, s_band, s_mtrx, busy, lock
  );

  modport slave (
    input  start, cmp_valid, fast,
    output cmp_req, s_band, s_mtrx, busy, lock
  );
endinterface

// File: rtl/flb_search_ctrl.sv
// FLB search controller: two-phase successive-approximation search of the DCO
// coarse band code, then the fine matrix code. Each trial code is followed by
// SETTLE_CYC settle cycles, a one-cycle cmp_req pulse, and a wait for the
// compare result (fast=1 means the DCO runs above target).
// Optional build macro FLB_TRACK_EN: after the search, the block enters TRACK
// instead of DONE and keeps nudging s_mtrx by one LSB per compare result.
module flb_search_ctrl #(
  parameter int SETTLE_CYC = 16
) (
  input logic          clk,
  input logic          rst,
  flb_search_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_MEAS   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef FLB_TRACK_EN
  localparam logic [2:0] ST_TRACK  = 3'd4;
`endif

  localparam logic PH_BAND = 1'b0;
  localparam logic PH_MTRX = 1'b1;

  // Last value of the settle counter; SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [2:0] state_q, state_d;
  logic       phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] band_q, band_d;
  logic [7:0] mtrx_q, mtrx_d;
  logic       cmp_req_q, cmp_req_d;
`ifdef FLB_TRACK_EN
  logic       trk_wait_q, trk_wait_d;
`endif

  logic [7:0] trial;
  logic       can_start;

  // Next-state logic: settle timing, SAR bit decisions, phase hand-over, restart.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    band_d    = band_q;
    mtrx_d    = mtrx_q;
    cmp_req_d = 1'b0;
`ifdef FLB_TRACK_EN
    trk_wait_d = trk_wait_q;
`endif
    trial     = (phase_q == PH_MTRX) ? mtrx_q : band_q;
    can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d     = '0;
          cmp_req_d = 1'b1;
          state_d   = ST_MEAS;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_MEAS: begin
        if (bus.cmp_valid) begin
          // Too fast: the trial bit overshoots, drop it; otherwise keep it.
          if (bus.fast) trial[bit_q] = 1'b0;
          if (bit_q != 3'd0) begin
            trial[bit_q - 3'd1] = 1'b1;
            bit_d   = bit_q - 3'd1;
            state_d = ST_SETTLE;
          end
          if (phase_q == PH_BAND) band_d = trial;
          else                    mtrx_d = trial;
          cnt_d = '0;
          if (bit_q == 3'd0) begin
            if (phase_q == PH_BAND) begin
              // Band is final; start the fine search from mid-scale.
              phase_d = PH_MTRX;
              bit_d   = 3'd7;
              mtrx_d  = 8'h80;
              state_d = ST_SETTLE;
            end else begin
`ifdef FLB_TRACK_EN
              trk_wait_d = 1'b0;
              state_d    = ST_TRACK;
`else
              state_d    = ST_DONE;
`endif
            end
          end
        end
      end

`ifdef FLB_TRACK_EN
      ST_TRACK: begin
        if (!trk_wait_q) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d      = '0;
            cmp_req_d  = 1'b1;
            trk_wait_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (bus.cmp_valid) begin
          // One-LSB correction of the fine code, saturating at both ends.
          if (bus.fast) begin
            if (mtrx_q != 8'h00) mtrx_d = mtrx_q - 8'd1;
          end else begin
            if (mtrx_q != 8'hFF) mtrx_d = mtrx_q + 8'd1;
          end
          trk_wait_d = 1'b0;
        end
      end
`endif

      default: ;
    endcase

`ifdef FLB_TRACK_EN
    can_start = can_start || (state_q == ST_TRACK);
`endif

    // A start outside IDLE/DONE/TRACK is dropped; otherwise restart from mid-scale.
    if (bus.start && can_start) begin
      state_d   = ST_SETTLE;
      phase_d   = PH_BAND;
      bit_d     = 3'd7;
      cnt_d     = '0;
      band_d    = 8'h80;
      mtrx_d    = 8'h80;
      cmp_req_d = 1'b0;
`ifdef FLB_TRACK_EN
      trk_wait_d = 1'b0;
`endif
    end
  end

  // State registers; reset wins over every other input and clears all codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_BAND;
      bit_q     <= 3'd0;
      cnt_q     <= 8'd0;
      band_q    <= 8'h00;
      mtrx_q    <= 8'h00;
      cmp_req_q <= 1'b0;
`ifdef FLB_TRACK_EN
      trk_wait_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      band_q    <= band_d;
      mtrx_q    <= mtrx_d;
      cmp_req_q <= cmp_req_d;
`ifdef FLB_TRACK_EN
      trk_wait_q <= trk_wait_d;
`endif
    end
  end

  assign bus.cmp_req = cmp_req_q;
  assign bus.s_band  = band_q;
  assign bus.s_mtrx  = mtrx_q;
  assign bus.busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
`ifdef FLB_TRACK_EN
  assign bus.lock    = (state_q == ST_DONE) || (state_q == ST_TRACK);
`else
  assign bus.lock    = (state_q == ST_DONE);
`endif

endmodule
